// File: rtl/sid_pkg.sv
// Shared encodings and default geometry for the SID oscillator bank.
// Field codes select which per-voice register a bus write lands in.
package sid_pkg;

  localparam int DEF_NVOICES   = 3;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_FREQ_W    = 16;
  localparam int DEF_LFSR_W    = 23;
  localparam int DEF_LFSR_TAPA = 22;
  localparam int DEF_LFSR_TAPB = 17;
  localparam int DEF_NOISE_BIT = 19;

  typedef enum logic [1:0] {
    FIELD_FREQ_LO = 2'd0,
    FIELD_FREQ_HI = 2'd1,
    FIELD_CTRL    = 2'd2,
    FIELD_NONE    = 2'd3
  } field_e;

  localparam int CTRL_TEST = 0;
  localparam int CTRL_SYNC = 1;
  localparam int CTRL_W    = 2;

  // Hard-sync ring: each voice is reset by the MSB rise of the voice before it.
  function automatic int sync_src(input int voice, input int nvoices);
    return (voice + nvoices - 1) % nvoices;
  endfunction

endpackage

// File: rtl/sid_osc_voice.sv
// One SID voice: phase accumulator plus noise LFSR clocked by an accumulator bit.
// pre_rise_o is taken before sync so the bank ring never forms a combinational loop.
module sid_osc_voice
  import sid_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FREQ_W    = DEF_FREQ_W,
  parameter int LFSR_W    = DEF_LFSR_W,
  parameter int LFSR_TAPA = DEF_LFSR_TAPA,
  parameter int LFSR_TAPB = DEF_LFSR_TAPB,
  parameter int NOISE_BIT = DEF_NOISE_BIT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clk_en_i,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic              test_i,
  input  logic              sync_en_i,
  input  logic              sync_hit_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic              pre_rise_o
);

  logic [ACC_W-1:0]  acc_q, acc_d, raw;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign raw        = acc_q + ACC_W'(freq_i);
  assign pre_rise_o = !acc_q[ACC_W-1] && raw[ACC_W-1];

  // Test dominates sync; the LFSR steps on a rise of the final accumulator value.
  always_comb begin
    acc_d  = acc_q;
    lfsr_d = lfsr_q;
    if (clk_en_i) begin
      if (test_i) begin
        acc_d  = '0;
        lfsr_d = '1;
      end else begin
        acc_d = (sync_en_i && sync_hit_i) ? '0 : raw;
        if (!acc_q[NOISE_BIT] && acc_d[NOISE_BIT]) begin
          lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAPA] ^ lfsr_q[LFSR_TAPB]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q  <= '0;
      lfsr_q <= '1;
    end else begin
      acc_q  <= acc_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign acc_o  = acc_q;
  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sid_osc_bank.sv
// Bank of SID voices with a byte-wide freq/control register file and hard-sync ring.
// Writes land every clk; an advance in the same cycle still sees the old register values.
module sid_osc_bank
  import sid_pkg::*;
#(
  parameter int NVOICES   = DEF_NVOICES,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FREQ_W    = DEF_FREQ_W,
  parameter int LFSR_W    = DEF_LFSR_W,
  parameter int LFSR_TAPA = DEF_LFSR_TAPA,
  parameter int LFSR_TAPB = DEF_LFSR_TAPB,
  parameter int NOISE_BIT = DEF_NOISE_BIT,
  localparam int VOICE_W  = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      clk_en,
  input  logic                      wr_en,
  input  logic [VOICE_W-1:0]        wr_voice,
  input  logic [1:0]                wr_field,
  input  logic [7:0]                wr_data,
  output logic [NVOICES*ACC_W-1:0]  acc,
  output logic [NVOICES*LFSR_W-1:0] lfsr,
  output logic [NVOICES-1:0]        msb_rise
);

  localparam int LO_W = (FREQ_W < 8) ? FREQ_W : 8;

  logic [FREQ_W-1:0] freq_q [NVOICES];
  logic [FREQ_W-1:0] freq_d [NVOICES];
  logic [CTRL_W-1:0] ctrl_q [NVOICES];
  logic [CTRL_W-1:0] ctrl_d [NVOICES];
  logic [NVOICES-1:0] pre_rise, msb_rise_q, msb_rise_d;

  // Out-of-range voice indices simply match no entry and are dropped.
  always_comb begin
    freq_d = freq_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      for (int i = 0; i < NVOICES; i++) begin
        if (wr_voice == VOICE_W'(i)) begin
          case (wr_field)
            FIELD_FREQ_LO: begin
              for (int b = 0; b < LO_W; b++) freq_d[i][b] = wr_data[b];
            end
            FIELD_FREQ_HI: begin
              for (int b = 8; b < FREQ_W; b++) freq_d[i][b] = wr_data[b-8];
            end
            FIELD_CTRL: ctrl_d[i] = wr_data[CTRL_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign msb_rise_d = clk_en ? pre_rise : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NVOICES; i++) begin
        freq_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
      msb_rise_q <= '0;
    end else begin
      freq_q     <= freq_d;
      ctrl_q     <= ctrl_d;
      msb_rise_q <= msb_rise_d;
    end
  end

  for (genvar v = 0; v < NVOICES; v++) begin : g_voice
    localparam int SRC = sync_src(v, NVOICES);

    sid_osc_voice #(
      .ACC_W     (ACC_W),
      .FREQ_W    (FREQ_W),
      .LFSR_W    (LFSR_W),
      .LFSR_TAPA (LFSR_TAPA),
      .LFSR_TAPB (LFSR_TAPB),
      .NOISE_BIT (NOISE_BIT)
    ) u_voice (
      .clk        (clk),
      .n_reset    (n_reset),
      .clk_en_i   (clk_en),
      .freq_i     (freq_q[v]),
      .test_i     (ctrl_q[v][CTRL_TEST]),
      .sync_en_i  (ctrl_q[v][CTRL_SYNC]),
      .sync_hit_i (pre_rise[SRC]),
      .acc_o      (acc[v*ACC_W +: ACC_W]),
      .lfsr_o     (lfsr[v*LFSR_W +: LFSR_W]),
      .pre_rise_o (pre_rise[v])
    );
  end

  assign msb_rise = msb_rise_q;

endmodule
